// File: rtl/bit_stream_serializer_if.sv
// rtl/bit_stream_serializer_if.sv - parallel word load handshake for the bit stream serializer
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             msb_first;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        output msb_first,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  msb_first,
        output load_ready
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel-to-serial shifter feeding a serial sequence detector
module bit_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bit_stream_serializer_if.slave load,
    output logic                   ser_out,
    output logic                   ser_en,
    output logic                   bit_strobe,
    output logic                   done,
    output logic                   busy,
    output logic [CNT_W-1:0]       word_count
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             msb_r;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             bit_end;
    logic             last;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load_ready is decoded only from registered state so it never loops back on load_valid
    always_comb begin
        state_nxt       = state;
        bit_end         = (state == SHIFT) && (div_cnt == DIV_LAST);
        last            = bit_end && (bit_cnt == '0);
        load.load_ready = (state == IDLE) || last;
        accept          = load.load_valid && load.load_ready;
        busy            = (state == SHIFT);
        bit_strobe      = (state == SHIFT) && (div_cnt == '0);
        done            = last;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg      <= '0;
            msb_r      <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_out    <= 1'b0;
            ser_en     <= 1'b0;
            word_count <= '0;
        end else begin
            if (last) begin
                word_count <= word_count + CNT_W'(1);
            end
            // The first bit goes straight to ser_out; shreg keeps the remaining bits at the head end
            if (accept) begin
                msb_r   <= load.msb_first;
                ser_out <= load.msb_first ? load.load_data[WIDTH-1] : load.load_data[0];
                shreg   <= load.msb_first ? {load.load_data[WIDTH-2:0], 1'b0}
                                          : {1'b0, load.load_data[WIDTH-1:1]};
                ser_en  <= 1'b1;
                bit_cnt <= BIT_FIRST;
                div_cnt <= '0;
            end else if (state == SHIFT) begin
                if (last) begin
                    ser_out <= 1'b0;
                    ser_en  <= 1'b0;
                    div_cnt <= '0;
                end else if (bit_end) begin
                    ser_out <= msb_r ? shreg[WIDTH-1] : shreg[0];
                    shreg   <= msb_r ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                    bit_cnt <= bit_cnt - BW'(1);
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end
endmodule
